// File: rtl/ntt_job_sequencer.sv
// Job controller for the NTT/INTT engine: streams 256 coefficients into the engine RAM, runs it,
// and drains 128 packed result words from the engine FIFO through a 2-entry skid buffer.
module ntt_job_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int NWORDS  = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        go_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        job_done,
  output logic        err,
  output logic        ntt_rst,
  output logic        ntt_start,
  output logic        ntt_mode,
  output logic        ntt_we,
  output logic [7:0]  ntt_addr_a,
  output logic [7:0]  ntt_addr_b,
  output logic [15:0] ntt_data_a,
  output logic [15:0] ntt_data_b,
  input  logic        ntt_done,
  output logic        fifo_rd_req,
  input  logic [31:0] fifo_rd_dat,
  input  logic        fifo_rd_empty,
  output logic [2:0]  dbg_state
);

  // Handshakes: a word moves on a rising clk edge where valid && ready are both high; valid
  // never depends on ready, and once out_valid is raised out_data holds until that transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LWAIT = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [6:0]      K_LAST   = 7'(NWORDS - 1);
  localparam logic [7:0]      N_WORDS8 = 8'(NWORDS);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);

  state_t        state;
  logic [6:0]    k;
  logic [TW-1:0] tcnt;
  logic [7:0]    issued;
  logic [7:0]    delivered;
  logic [1:0]    occ;
  logic          pend;
  logic [31:0]   buf0;
  logic [31:0]   buf1;
  logic          pop;
  logic          accept;
  logic          go_acc;
  logic [2:0]    room_use;

  assign go_acc    = (state == S_IDLE) && go;
  assign accept    = (state == S_LOAD) && in_valid && in_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign pop       = out_valid && out_ready;
  assign dbg_state = state;

  // Slots the buffer will hold after this cycle if a read is issued now.
  assign room_use    = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign fifo_rd_req = (state == S_DRAIN) && !fifo_rd_empty && (room_use < 3'd2) &&
                       (issued < N_WORDS8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      job_done   <= 1'b0;
      err        <= 1'b0;
      ntt_rst    <= 1'b1;
      ntt_start  <= 1'b1;
      ntt_mode   <= 1'b0;
      ntt_we     <= 1'b0;
      ntt_addr_a <= 8'd0;
      ntt_addr_b <= 8'd0;
      ntt_data_a <= 16'd0;
      ntt_data_b <= 16'd0;
      k          <= 7'd0;
      tcnt       <= '0;
    end else begin
      ntt_we   <= 1'b0;
      job_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            ntt_mode  <= go_mode;
            ntt_rst   <= 1'b1;
            ntt_start <= 1'b1;
            k         <= 7'd0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ntt_we     <= 1'b1;
            ntt_addr_a <= {k, 1'b0};
            ntt_addr_b <= {k, 1'b1};
            ntt_data_a <= in_data[31:16];
            ntt_data_b <= in_data[15:0];
            k          <= k + 7'd1;
            if (k == K_LAST) begin
              state    <= S_LWAIT;
              in_ready <= 1'b0;
              ntt_rst  <= 1'b0;
            end
          end
        end
        S_LWAIT: begin
          state     <= S_RUN;
          ntt_start <= 1'b0;
          tcnt      <= '0;
        end
        S_RUN: begin
          if (ntt_done) begin
            state <= S_DRAIN;
          end else if (tcnt == T_LAST) begin
            state     <= S_IDLE;
            err       <= 1'b1;
            busy      <= 1'b0;
            ntt_rst   <= 1'b1;
            ntt_start <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DRAIN: begin
          if (pop && (delivered == N_WORDS8 - 8'd1)) begin
            state     <= S_FIN;
            job_done  <= 1'b1;
            ntt_rst   <= 1'b1;
            ntt_start <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Skid buffer: a read issued in cycle n returns data in n+1, which lands in the buffer at n+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      occ       <= 2'd0;
      buf0      <= 32'd0;
      buf1      <= 32'd0;
      issued    <= 8'd0;
      delivered <= 8'd0;
    end else begin
      pend <= fifo_rd_req;
      if (go_acc) begin
        issued    <= 8'd0;
        delivered <= 8'd0;
      end else begin
        if (fifo_rd_req) issued <= issued + 8'd1;
        if (pop) delivered <= delivered + 8'd1;
      end
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_rd_dat;
          else buf1 <= fifo_rd_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rd_dat;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rd_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// Bench for ntt_job_sequencer: engine RAM/FIFO models, scoreboard on the result stream,
// directed jobs covering load, drain back-pressure, FIFO underrun, reset abort and timeout.
module tb_ntt_job_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, go_mode, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        busy, job_done, err, ntt_rst, ntt_start, ntt_mode, ntt_we;
  logic [7:0]  ntt_addr_a, ntt_addr_b;
  logic [15:0] ntt_data_a, ntt_data_b;
  logic        ntt_done, fifo_rd_req, fifo_rd_empty;
  logic [31:0] fifo_rd_dat = 32'd0;
  logic [2:0]  dbg_state;

  logic        go2;
  logic        to_in_ready, to_out_valid, to_busy, to_job_done, to_err, to_ntt_rst;
  logic        to_ntt_start, to_ntt_mode, to_ntt_we, to_fifo_rd_req;
  logic [31:0] to_out_data;
  logic [7:0]  to_addr_a, to_addr_b;
  logic [15:0] to_data_a, to_data_b;
  logic [2:0]  to_dbg_state;

  ntt_job_sequencer u_dut (
    .clk(clk), .rst(rst), .go(go), .go_mode(go_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .job_done(job_done), .err(err),
    .ntt_rst(ntt_rst), .ntt_start(ntt_start), .ntt_mode(ntt_mode), .ntt_we(ntt_we),
    .ntt_addr_a(ntt_addr_a), .ntt_addr_b(ntt_addr_b),
    .ntt_data_a(ntt_data_a), .ntt_data_b(ntt_data_b),
    .ntt_done(ntt_done), .fifo_rd_req(fifo_rd_req), .fifo_rd_dat(fifo_rd_dat),
    .fifo_rd_empty(fifo_rd_empty), .dbg_state(dbg_state)
  );

  ntt_job_sequencer #(.TIMEOUT(64)) u_to (
    .clk(clk), .rst(rst), .go(go2), .go_mode(1'b0),
    .in_valid(1'b1), .in_ready(to_in_ready), .in_data(32'd0),
    .out_valid(to_out_valid), .out_ready(1'b1), .out_data(to_out_data),
    .busy(to_busy), .job_done(to_job_done), .err(to_err),
    .ntt_rst(to_ntt_rst), .ntt_start(to_ntt_start), .ntt_mode(to_ntt_mode), .ntt_we(to_ntt_we),
    .ntt_addr_a(to_addr_a), .ntt_addr_b(to_addr_b),
    .ntt_data_a(to_data_a), .ntt_data_b(to_data_b),
    .ntt_done(1'b0), .fifo_rd_req(to_fifo_rd_req), .fifo_rd_dat(32'd0),
    .fifo_rd_empty(1'b1), .dbg_state(to_dbg_state)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fifo_mem[0:1023];
  int          fifo_wp = 0;
  int          fifo_rp = 0;
  int          wr_cnt = 0;
  logic [7:0]  hist_a[0:1023];
  logic [7:0]  hist_b[0:1023];
  logic [15:0] hist_da[0:1023];
  logic [15:0] hist_db[0:1023];
  int          job_words = 0;
  int          req_cnt = 0;
  int          pop_cnt = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = 32'd0;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Engine result FIFO model: data appears the cycle after a read request.
  assign fifo_rd_empty = (fifo_rp == fifo_wp);
  always @(posedge clk) begin
    if (fifo_rd_req && (fifo_rp != fifo_wp)) begin
      fifo_rd_dat <= fifo_mem[fifo_rp];
      fifo_rp     <= fifo_rp + 1;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: result scoreboard, stream stability, read-credit bound, RAM write capture.
  always @(negedge clk) begin
    if (hold_v) begin
      chk("out_hold_valid", 32'(out_valid), 32'd1);
      chk("out_hold_data", out_data, hold_d);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_extra: got %0h want no word", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
      job_words++;
      pop_cnt++;
    end
    if (fifo_rd_req) begin
      req_cnt++;
      chk("rd_req_empty", 32'(fifo_rd_empty), 32'd0);
      chk("inflight_le2", 32'((req_cnt - pop_cnt) <= 2), 32'd1);
    end
    if (ntt_we) begin
      hist_a[wr_cnt]  = ntt_addr_a;
      hist_b[wr_cnt]  = ntt_addr_b;
      hist_da[wr_cnt] = ntt_data_a;
      hist_db[wr_cnt] = ntt_data_b;
      chk("addr_pair", 32'(ntt_addr_b), 32'(ntt_addr_a) + 32'd1);
      wr_cnt++;
    end
    if (job_done) begin
      chk("job_words", job_words, 128);
      job_words = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_go(input logic m);
    @(posedge clk);
    #1;
    go      = 1'b1;
    go_mode = m;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic load_words(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = {16'(2 * k), 16'(2 * k + 1)};
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("load_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic preload(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wp] = base + 32'(i);
      exp_q.push_back(base + 32'(i));
      fifo_wp++;
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!job_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("job_done_seen", 32'(job_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n, errs;
    rst = 1'b0; go = 1'b0; go_mode = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    ntt_done = 1'b0; go2 = 1'b0;
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_job_done", 32'(job_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_we", 32'(ntt_we), 0);
    chk("rst_rd_req", 32'(fifo_rd_req), 0);
    chk("rst_mode", 32'(ntt_mode), 0);
    chk("rst_ntt_rst", 32'(ntt_rst), 1);
    chk("rst_ntt_start", 32'(ntt_start), 1);
    chk("rst_addr", {ntt_addr_a, ntt_addr_b, ntt_data_a}, 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b1;
    cyc(2);

    // Job 1: NTT, back-to-back load, done after ~500 RUN cycles, full-rate drain
    base = wr_cnt;
    pulse_go(1'b0);
    @(negedge clk);
    chk("go_in_ready", 32'(in_ready), 1);
    chk("go_busy", 32'(busy), 1);
    load_words(128);
    @(negedge clk);
    chk("lwait_state", 32'(dbg_state), 2);
    chk("lwait_start", 32'(ntt_start), 1);
    chk("lwait_rst", 32'(ntt_rst), 0);
    chk("lwait_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("run_state", 32'(dbg_state), 3);
    chk("run_start", 32'(ntt_start), 0);
    chk("run_mode", 32'(ntt_mode), 0);
    chk("we_count", wr_cnt - base, 128);
    chk("first_addr_a", 32'(hist_a[base]), 0);
    chk("last_addr_a", 32'(hist_a[base + 127]), 254);
    chk("last_addr_b", 32'(hist_b[base + 127]), 255);
    chk("last_data_a", 32'(hist_da[base + 127]), 254);
    chk("last_data_b", 32'(hist_db[base + 127]), 255);
    errs = 0;
    for (int i = 0; i < 128; i++)
      if (hist_da[base + i] != 16'(2 * i) || hist_db[base + i] != 16'(2 * i + 1)) errs++;
    chk("ram_data", errs, 0);
    cyc(98);
    pulse_go(1'b1);
    @(negedge clk);
    chk("go_in_run_state", 32'(dbg_state), 3);
    chk("go_in_run_mode", 32'(ntt_mode), 0);
    preload(32'hA500_0000, 128);
    cyc(396);
    @(posedge clk);
    #1;
    ntt_done = 1'b1;
    @(negedge clk);
    chk("rd_req_in_run", 32'(fifo_rd_req), 0);
    @(negedge clk);
    chk("first_rd_req", 32'(fifo_rd_req), 1);
    chk("drain_state", 32'(dbg_state), 4);
    @(negedge clk);
    chk("out_valid_early", 32'(out_valid), 0);
    @(negedge clk);
    chk("first_out_valid", 32'(out_valid), 1);
    wait_done(300, n);
    chk("drain_cycles", n, 128);
    chk("fin_state", 32'(dbg_state), 5);
    chk("fin_ntt_rst", 32'(ntt_rst), 1);
    @(negedge clk);
    chk("after_busy", 32'(busy), 0);
    chk("after_job_done", 32'(job_done), 0);
    chk("exp_empty_1", exp_q.size(), 0);
    ntt_done = 1'b0;

    // Job 2: done already high, random ready, FIFO underrun, ready held low, go in DRAIN
    ntt_done = 1'b1;
    ready_mode = 1;
    preload(32'hB600_0000, 60);
    pulse_go(1'b0);
    load_words(128);
    @(negedge clk);
    chk("lwait_state_2", 32'(dbg_state), 2);
    @(negedge clk);
    chk("run_state_2", 32'(dbg_state), 3);
    @(negedge clk);
    chk("drain_next_cycle", 32'(dbg_state), 4);
    chk("rd_req_2", 32'(fifo_rd_req), 1);
    pulse_go(1'b1);
    @(negedge clk);
    chk("go_in_drain_state", 32'(dbg_state), 4);
    chk("go_in_drain_mode", 32'(ntt_mode), 0);
    cyc(250);
    chk("stall_out_valid", 32'(out_valid), 0);
    chk("stall_rd_req", 32'(fifo_rd_req), 0);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_exp", exp_q.size(), 0);
    ready_mode = 2;
    cyc(2);
    preload(32'hB600_003C, 68);
    cyc(10);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_head", out_data, 32'hB600_003C);
    chk("full_rd_req", 32'(fifo_rd_req), 0);
    chk("full_exp", exp_q.size(), 68);
    ready_mode = 1;
    wait_done(800, n);
    @(negedge clk);
    chk("after_busy_2", 32'(busy), 0);
    chk("exp_empty_2", exp_q.size(), 0);
    ntt_done = 1'b0;
    ready_mode = 0;

    // Job 3: reset in the middle of the load
    pulse_go(1'b1);
    load_words(60);
    in_valid = 1'b1;
    in_data  = {16'd120, 16'd121};
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_we", 32'(ntt_we), 0);
    chk("mid_rst_ntt_rst", 32'(ntt_rst), 1);
    chk("mid_rst_start", 32'(ntt_start), 1);
    chk("mid_rst_mode", 32'(ntt_mode), 0);
    chk("mid_rst_addr", {ntt_addr_a, ntt_addr_b, ntt_data_a}, 0);
    chk("mid_rst_data_b", 32'(ntt_data_b), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    in_valid = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // Job 4: fresh INTT job after the abort
    base = wr_cnt;
    pulse_go(1'b1);
    load_words(128);
    cyc(2);
    chk("run_state_4", 32'(dbg_state), 3);
    chk("run_mode_4", 32'(ntt_mode), 1);
    chk("we_count_4", wr_cnt - base, 128);
    chk("first_addr_a_4", 32'(hist_a[base]), 0);
    chk("first_addr_b_4", 32'(hist_b[base]), 1);
    chk("first_data_a_4", 32'(hist_da[base]), 0);
    chk("last_addr_b_4", 32'(hist_b[base + 127]), 255);
    preload(32'hC700_0000, 128);
    cyc(20);
    @(posedge clk);
    #1;
    ntt_done = 1'b1;
    wait_done(400, n);
    @(negedge clk);
    chk("after_busy_4", 32'(busy), 0);
    chk("exp_empty_4", exp_q.size(), 0);
    chk("main_err", 32'(err), 0);
    ntt_done = 1'b0;

    // Timeout on the TIMEOUT=64 instance
    @(posedge clk);
    #1;
    go2 = 1'b1;
    @(posedge clk);
    #1;
    go2 = 1'b0;
    n = 0;
    while (to_ntt_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_run_seen", 32'(to_ntt_start), 0);
    n = 0;
    while (!to_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_busy", 32'(to_busy), 0);
    chk("to_start", 32'(to_ntt_start), 1);
    chk("to_state", 32'(to_dbg_state), 0);
    cyc(3);
    chk("to_err_sticky", 32'(to_err), 1);
    @(posedge clk);
    #1;
    go2 = 1'b1;
    @(posedge clk);
    #1;
    go2 = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(to_err), 0);
    chk("to_busy_again", 32'(to_busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
